fft_zeropad_buffer: RTL and testbench

FFT_ZEROPAD_BUFFER -- requirements
Module: fft_zeropad_buffer

---
 rtl/fft_zeropad_buffer.sv | 184 ++++++++++++++++++
 tb/tb_fft_zeropad_buffer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_zeropad_buffer.sv
// Buffers LANES-wide ADC words and replays them one sample per clk as NFFT-sample frames
// (bin data, then zero pad). Define FIFO_IN_OVF_STICKY_EN to make overflow sticky until the next start.
module fft_zeropad_buffer #(
    parameter int BIT_WIDTH = 14,
    parameter int LANES     = 2,
    parameter int NFFT      = 1024,
    parameter int ADDR_W    = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BIT_WIDTH*LANES-1:0] data_in,
    input  logic                       start,
    input  logic [15:0]                n_points_per_bin,
    input  logic [15:0]                mirror_position,
    input  logic [15:0]                end_position,
    output logic [BIT_WIDTH-1:0]       data_out,
    output logic                       data_valid,
    output logic                       frame_first,
    output logic                       frame_last,
    output logic [7:0]                 bin_index,
    output logic                       busy,
    output logic                       overflow
);
    // state | meaning
    // IDLE  | no frame in flight, waiting for a full bin (or the tail after acquisition)
    // DATA  | reading one buffered sample per clk
    // PAD   | emitting zeros until the frame holds NFFT samples
    typedef enum logic [1:0] {RD_IDLE, RD_DATA, RD_PAD} rd_state_t;

    localparam int          DEPTH    = 2**ADDR_W;
    localparam int          CW       = ADDR_W + 1;
    localparam logic [15:0] POS_LAST = 16'(NFFT - 1);

    rd_state_t            rd_state_q, rd_state_d;
    logic [BIT_WIDTH-1:0] mem [DEPTH];
    logic                 acq_q, acq_d;
    logic [15:0]          npb_q, mirror_q, end_q;
    logic [15:0]          word_q, word_d;
    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d, avail;
    logic [15:0]          pos_q, pos_d, left_q, left_d, len_new;
    logic [BIT_WIDTH-1:0] dout_q;
    logic                 valid_q, first_q, last_q, ovf_q, ovf_d;
    logic [7:0]           bin_q, bin_d;
    logic                 accept, in_window, wr_req, drop, wr_en, rd_en, enter;

    assign busy   = acq_q | (count_q != '0) | (rd_state_q != RD_IDLE) | valid_q;
    assign accept = start && !busy && (n_points_per_bin != 16'd0)
                    && (32'(n_points_per_bin) <= 32'(NFFT));

    assign in_window = (32'(word_q) * 32'(LANES) < 32'(npb_q))
                       || ((word_q >= mirror_q) && (word_q < end_q));

    always_comb begin
        acq_d  = acq_q;
        word_d = word_q;
        wr_req = 1'b0;
        if (accept) begin
            acq_d  = 1'b1;
            word_d = '0;
        end else if (acq_q) begin
            if (word_q >= end_q) begin
                acq_d = 1'b0;
            end else begin
                wr_req = in_window;
                word_d = word_q + 16'd1;
                if (word_d == end_q) acq_d = 1'b0;
            end
        end
    end

    // A word is accepted only if every lane fits; otherwise it is dropped whole.
    assign drop     = wr_req && (32'(count_q) + 32'(LANES) > 32'(DEPTH));
    assign wr_en    = wr_req && !drop;
    assign rd_en    = (rd_state_q == RD_DATA);
    assign wr_ptr_d = wr_ptr_q + (wr_en ? ADDR_W'(LANES) : '0);
    assign count_d  = count_q + (wr_en ? CW'(LANES) : '0) - CW'(rd_en);

    // Occupancy after this cycle's read decides whether the next frame may start.
    assign avail   = count_q - CW'(rd_en);
    assign enter   = (avail != '0) && ((32'(avail) >= 32'(npb_q)) || !acq_q);
    assign len_new = (32'(avail) < 32'(npb_q)) ? 16'(avail) : npb_q;

    always_comb begin
        rd_state_d = rd_state_q;
        pos_d      = pos_q;
        left_d     = left_q;
        rd_ptr_d   = rd_ptr_q;
        case (rd_state_q)
            RD_IDLE: begin
                pos_d = '0;
                if (enter) begin
                    rd_state_d = RD_DATA;
                    left_d     = len_new;
                end
            end
            RD_DATA: begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                left_d   = left_q - 16'd1;
                pos_d    = pos_q + 16'd1;
                if (left_q == 16'd1) rd_state_d = RD_PAD;
            end
            RD_PAD: pos_d = pos_q + 16'd1;
            default: rd_state_d = RD_IDLE;
        endcase
        if (rd_state_q != RD_IDLE && pos_q == POS_LAST) begin
            pos_d = '0;
            if (enter) begin
                rd_state_d = RD_DATA;
                left_d     = len_new;
            end else begin
                rd_state_d = RD_IDLE;
            end
        end
    end

    always_comb begin
        bin_d = bin_q;
        if (accept) bin_d = '0;
        else if (last_q) bin_d = bin_q + 8'd1;
`ifdef FIFO_IN_OVF_STICKY_EN
        ovf_d = accept ? 1'b0 : (ovf_q | drop);
`else
        ovf_d = drop;
`endif
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                mem[wr_ptr_q + ADDR_W'(l)] <= data_in[l*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= RD_IDLE;
            acq_q      <= 1'b0;
            npb_q      <= '0;
            mirror_q   <= '0;
            end_q      <= '0;
            word_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pos_q      <= '0;
            left_q     <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            bin_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            acq_q      <= acq_d;
            word_q     <= word_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pos_q      <= pos_d;
            left_q     <= left_d;
            bin_q      <= bin_d;
            ovf_q      <= ovf_d;
            if (accept) begin
                npb_q    <= n_points_per_bin;
                mirror_q <= mirror_position;
                end_q    <= end_position;
            end
            dout_q  <= rd_en ? mem[rd_ptr_q] : '0;
            valid_q <= (rd_state_q != RD_IDLE);
            first_q <= (rd_state_q != RD_IDLE) && (pos_q == '0);
            last_q  <= (rd_state_q != RD_IDLE) && (pos_q == POS_LAST);
        end
    end

    assign data_out    = dout_q;
    assign data_valid  = valid_q;
    assign frame_first = first_q;
    assign frame_last  = last_q;
    assign bin_index   = bin_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_fft_zeropad_buffer.sv
// Directed bench for fft_zeropad_buffer: table of acquisition windows with hand-computed frame
// counts, plus hand sequences for ignored starts, mid-frame reset and a small overflowing buffer.
module tb_fft_zeropad_buffer;
    localparam int BW   = 14;
    localparam int NFFT = 1024;
    localparam int TMO  = 12000;
`ifdef FIFO_IN_OVF_STICKY_EN
    localparam int OVF_STICKY = 1;
`else
    localparam int OVF_STICKY = 0;
`endif

    typedef struct {
        int npb; int mirror; int endp;
        int frames; int last_len; int b2b;
        int poke; int abort_at;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2*BW-1:0] data_in = '0;
    logic          start = 1'b0, start_s = 1'b0;
    logic [15:0]   npb_in = '0, mirror_in = '0, end_in = '0;
    logic [BW-1:0] data_out, s_data_out;
    logic          data_valid, frame_first, frame_last, busy, overflow;
    logic          s_data_valid, s_frame_first, s_frame_last, s_busy, s_overflow;
    logic [7:0]    bin_index, s_bin_index;

    always #5 clk = ~clk;

    fft_zeropad_buffer dut (
        .clk(clk), .rst(rst), .data_in(data_in), .start(start),
        .n_points_per_bin(npb_in), .mirror_position(mirror_in), .end_position(end_in),
        .data_out(data_out), .data_valid(data_valid), .frame_first(frame_first),
        .frame_last(frame_last), .bin_index(bin_index), .busy(busy), .overflow(overflow)
    );

    fft_zeropad_buffer #(.ADDR_W(8)) dut_s (
        .clk(clk), .rst(rst), .data_in(data_in), .start(start_s),
        .n_points_per_bin(npb_in), .mirror_position(mirror_in), .end_position(end_in),
        .data_out(s_data_out), .data_valid(s_data_valid), .frame_first(s_frame_first),
        .frame_last(s_frame_last), .bin_index(s_bin_index), .busy(s_busy), .overflow(s_overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[7];

    // expected sample stream and frame monitor state
    int exp_q[$];
    int e_idx, m_npb, flen, pos, merr;
    int frames, b2b, gaps, stray, last_len;
    bit in_frame, prev_last;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [2*BW-1:0] word(input int k);
        logic [BW-1:0] lo, hi;
        lo = BW'(2*k);
        hi = BW'(2*k + 1);
        return {hi, lo};
    endfunction

    task automatic mon_step();
        int e;
        if (data_valid) begin
            if (frame_first) begin
                if (in_frame) gaps++;
                if (prev_last) b2b++;
                in_frame = 1'b1;
                pos  = 0;
                merr = 0;
                flen = exp_q.size() - e_idx;
                if (flen > m_npb) flen = m_npb;
            end
            if (!in_frame) begin
                stray++;
            end else begin
                e = 0;
                if (pos < flen) begin
                    e = exp_q[e_idx];
                    e_idx++;
                end
                if (int'(data_out) != e) merr++;
                if (frame_last) begin
                    check("frame_len", pos + 1, NFFT);
                    check("frame_data_errs", merr, 0);
                    check("bin_index", bin_index, frames);
                    frames++;
                    last_len = flen;
                    in_frame = 1'b0;
                end
                pos++;
            end
        end else if (in_frame) begin
            gaps++;
        end
        prev_last = data_valid && frame_last;
    endtask

    task automatic run_case(input vec_t v);
        int cyc;
        exp_q.delete();
        for (int k = 0; k < v.endp; k++) begin
            if (k*2 < v.npb || (k >= v.mirror && k < v.endp)) begin
                exp_q.push_back((2*k) & 16'h3fff);
                exp_q.push_back((2*k + 1) & 16'h3fff);
            end
        end
        e_idx = 0; m_npb = v.npb; frames = 0; b2b = 0; gaps = 0; stray = 0;
        last_len = 0; in_frame = 1'b0; prev_last = 1'b0;
        @(negedge clk);
        npb_in = 16'(v.npb); mirror_in = 16'(v.mirror); end_in = 16'(v.endp);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        data_in = word(0);
        check("busy_after_start", busy, 1);
        check("bin_index_at_start", bin_index, 0);
        cyc = 0;
        while ((busy || cyc < 4) && cyc < TMO) begin
            @(negedge clk);
            mon_step();
            cyc++;
            data_in = word(cyc);
            if (v.poke != 0 && cyc == 20) begin
                npb_in = 16'd100; mirror_in = 16'd0; end_in = 16'd2;
                start = 1'b1;
            end
            if (v.poke != 0 && cyc == 21) begin
                start = 1'b0;
                npb_in = 16'(v.npb); mirror_in = 16'(v.mirror); end_in = 16'(v.endp);
            end
            if (v.abort_at != 0 && cyc == v.abort_at) begin
                check("pad_valid", data_valid, 1);
                check("pad_zero", data_out, 0);
                @(posedge clk);
                #2 rst = 1'b1;
                @(posedge clk);
                #1;
                check("abort_data_out", data_out, 0);
                check("abort_valid", data_valid, 0);
                check("abort_first", frame_first, 0);
                check("abort_last", frame_last, 0);
                check("abort_bin", bin_index, 0);
                check("abort_busy", busy, 0);
                check("abort_ovf", overflow, 0);
                @(negedge clk);
                rst = 1'b0;
                repeat (3) @(negedge clk);
                return;
            end
        end
        check("done_before_timeout", busy, 0);
        check("frame_count", frames, v.frames);
        check("last_frame_len", last_len, v.last_len);
        check("back_to_back", b2b, v.b2b);
        check("valid_gaps", gaps, 0);
        check("stray_valid", stray, 0);
        check("samples_left", exp_q.size() - e_idx, 0);
        check("overflow_idle", overflow, 0);
    endtask

    task automatic ignored_start(input int npb);
        @(negedge clk);
        npb_in = 16'(npb); mirror_in = 16'd0; end_in = 16'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("ignored_start_busy", busy, 0);
        check("ignored_start_valid", data_valid, 0);
    endtask

    task automatic ovf_case();
        int cyc, s_frames, s_gaps, s_badlen, s_pos;
        bit s_in, s_seen;
        s_frames = 0; s_gaps = 0; s_badlen = 0; s_pos = 0; s_in = 1'b0; s_seen = 1'b0;
        @(negedge clk);
        npb_in = 16'd250; mirror_in = 16'd0; end_in = 16'd1500;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        data_in = word(0);
        cyc = 0;
        while ((s_busy || cyc < 4) && cyc < TMO) begin
            @(negedge clk);
            if (s_data_valid) begin
                if (s_frame_first) begin
                    if (s_in) s_gaps++;
                    s_in = 1'b1;
                    s_pos = 0;
                end
                if (s_frame_last) begin
                    if (s_pos + 1 != NFFT) s_badlen++;
                    s_frames++;
                    s_in = 1'b0;
                end
                s_pos++;
            end else if (s_in) begin
                s_gaps++;
            end
            if (s_overflow) s_seen = 1'b1;
            cyc++;
            data_in = word(cyc);
        end
        check("ovf_done_before_timeout", s_busy, 0);
        check("ovf_seen", s_seen, 1);
        check("ovf_frames_nonzero", s_frames > 0, 1);
        check("ovf_valid_gaps", s_gaps, 0);
        check("ovf_frame_len_errs", s_badlen, 0);
        check("ovf_after_window", s_overflow, OVF_STICKY);
        @(negedge clk);
        npb_in = 16'd0;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        @(negedge clk);
        check("ovf_after_ignored_start", s_overflow, OVF_STICKY);
        check("ovf_ignored_busy", s_busy, 0);
        npb_in = 16'd10; mirror_in = 16'd0; end_in = 16'd5;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        check("ovf_cleared_by_start", s_overflow, 0);
        check("ovf_new_busy", s_busy, 1);
        check("ovf_new_bin_index", s_bin_index, 0);
    endtask

    initial begin
        vecs[0] = '{250, 200, 1200, 9, 250, 8, 0, 0};
        vecs[1] = '{250, 200, 1140, 9, 130, 8, 0, 0};
        vecs[2] = '{1024, 512, 1024, 2, 1024, 1, 0, 0};
        vecs[3] = '{100, 50, 60, 2, 20, 1, 0, 0};
        vecs[4] = '{250, 100, 130, 2, 10, 1, 1, 0};
        vecs[5] = '{250, 200, 1200, 0, 0, 0, 0, 600};
        vecs[6] = '{250, 200, 1200, 9, 250, 8, 0, 0};

        repeat (3) @(negedge clk);
        check("rst_data_out", data_out, 0);
        check("rst_valid", data_valid, 0);
        check("rst_first", frame_first, 0);
        check("rst_last", frame_last, 0);
        check("rst_bin", bin_index, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        ignored_start(0);
        ignored_start(2000);
        ignored_start(1025);

        for (int i = 0; i < 7; i++) run_case(vecs[i]);

        ovf_case();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
